fractal_param_sequencer: RTL and testbench

Control-plane sequencer for the Julia-set generator. It holds host-written shadow copies of the generator's view and shape parameters and commits them atomically at frame boundaries. It can optionally animate cr/ci by a fixed step every frame, and it sequences the generator's synchronous reset whenever the frame size changes. It sits between the host register interface and the generator; its outputs drive the generator's configuration inputs and its resetn.

---
 rtl/fractal_param_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_fractal_param_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_param_sequencer.sv
// Shadow/active parameter sequencer for the Julia-set generator: host writes land in shadow,
// commit copies shadow to active at a frame boundary; a frame-size change pulses the generator reset.
module fractal_param_sequencer #(
   parameter int unsigned DEF_WIDTH  = 1920,
   parameter int unsigned DEF_HEIGHT = 1080,
   parameter int unsigned RST_CYCLES = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [3:0]  cfg_addr,
   input  logic [31:0] cfg_data,
   input  logic        gen_frame_start,
   input  logic        gen_data_enable,
   output logic        gen_resetn,
   output logic [15:0] width,
   output logic [15:0] height,
   output logic [31:0] cr,
   output logic [31:0] ci,
   output logic [31:0] dx,
   output logic [31:0] dy,
   output logic [31:0] x0,
   output logic [31:0] y0,
   output logic        pending,
   output logic [31:0] frame_count
);

   localparam logic [15:0] DEF_W = 16'(DEF_WIDTH);
   localparam logic [15:0] DEF_H = 16'(DEF_HEIGHT);
   localparam int CNT_W = $clog2(RST_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

   localparam logic [1:0] ST_RESET_GEN = 2'd0;
   localparam logic [1:0] ST_RUN       = 2'd1;
   localparam logic [1:0] ST_PENDING   = 2'd2;

   localparam logic [3:0] A_CR   = 4'd0;
   localparam logic [3:0] A_CI   = 4'd1;
   localparam logic [3:0] A_DX   = 4'd2;
   localparam logic [3:0] A_DY   = 4'd3;
   localparam logic [3:0] A_X0   = 4'd4;
   localparam logic [3:0] A_Y0   = 4'd5;
   localparam logic [3:0] A_SIZE = 4'd6;
   localparam logic [3:0] A_DCR  = 4'd7;
   localparam logic [3:0] A_DCI  = 4'd8;
   localparam logic [3:0] A_CTRL = 4'd9;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
   logic             gen_resetn_q, gen_resetn_d;
   logic             anim_en_q, anim_en_d;
   logic [31:0]      frame_count_q, frame_count_d;

   logic [15:0]      width_q, width_d, height_q, height_d;
   logic [31:0]      cr_q, cr_d, ci_q, ci_d, dx_q, dx_d;
   logic [31:0]      dy_q, dy_d, x0_q, x0_d, y0_q, y0_d;

   logic [15:0]      sh_width_q, sh_width_d, sh_height_q, sh_height_d;
   logic [31:0]      sh_cr_q, sh_cr_d, sh_ci_q, sh_ci_d, sh_dx_q, sh_dx_d;
   logic [31:0]      sh_dy_q, sh_dy_d, sh_x0_q, sh_x0_d, sh_y0_q, sh_y0_d;
   logic [31:0]      dcr_q, dcr_d, dci_q, dci_d;

   logic             fb;
   logic             wr_fire;
   logic             size_chg;

   // A frame boundary only counts once the generator is out of reset.
   assign fb       = gen_frame_start & gen_data_enable & gen_resetn_q;
   assign wr_fire  = cfg_valid & cfg_ready;
   assign size_chg = (sh_width_q != width_q) || (sh_height_q != height_q);

   assign cfg_ready   = (state_q == ST_RUN);
   assign pending     = (state_q == ST_PENDING);
   assign gen_resetn  = gen_resetn_q;
   assign frame_count = frame_count_q;
   assign width       = width_q;
   assign height      = height_q;
   assign cr          = cr_q;
   assign ci          = ci_q;
   assign dx          = dx_q;
   assign dy          = dy_q;
   assign x0          = x0_q;
   assign y0          = y0_q;

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      gen_resetn_d  = gen_resetn_q;
      anim_en_d     = anim_en_q;
      frame_count_d = frame_count_q;
      width_d       = width_q;
      height_d      = height_q;
      cr_d          = cr_q;
      ci_d          = ci_q;
      dx_d          = dx_q;
      dy_d          = dy_q;
      x0_d          = x0_q;
      y0_d          = y0_q;
      sh_width_d    = sh_width_q;
      sh_height_d   = sh_height_q;
      sh_cr_d       = sh_cr_q;
      sh_ci_d       = sh_ci_q;
      sh_dx_d       = sh_dx_q;
      sh_dy_d       = sh_dy_q;
      sh_x0_d       = sh_x0_q;
      sh_y0_d       = sh_y0_q;
      dcr_d         = dcr_q;
      dci_d         = dci_q;

      if (fb) begin
         frame_count_d = frame_count_q + 32'd1;
      end

      case (state_q)
         ST_RESET_GEN: begin
            if (rst_cnt_q == CNT_LAST) begin
               rst_cnt_d    = '0;
               gen_resetn_d = 1'b1;
               state_d      = ST_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            // Animation steps from the pre-write registers, so a same-cycle write only hits shadow.
            if (fb && anim_en_q) begin
               cr_d = cr_q + dcr_q;
               ci_d = ci_q + dci_q;
            end
            if (wr_fire) begin
               case (cfg_addr)
                  A_CR:   sh_cr_d = cfg_data;
                  A_CI:   sh_ci_d = cfg_data;
                  A_DX:   sh_dx_d = cfg_data;
                  A_DY:   sh_dy_d = cfg_data;
                  A_X0:   sh_x0_d = cfg_data;
                  A_Y0:   sh_y0_d = cfg_data;
                  A_SIZE: begin
                     sh_width_d  = cfg_data[15:0];
                     sh_height_d = cfg_data[31:16];
                  end
                  A_DCR:  dcr_d = cfg_data;
                  A_DCI:  dci_d = cfg_data;
                  A_CTRL: begin
                     anim_en_d = cfg_data[0];
                     if (cfg_data[1]) begin
                        state_d = ST_PENDING;
                     end
                  end
                  default: ;
               endcase
            end
         end

         ST_PENDING: begin
            // Commit wins over animation: active takes shadow verbatim.
            if (fb) begin
               width_d  = sh_width_q;
               height_d = sh_height_q;
               cr_d     = sh_cr_q;
               ci_d     = sh_ci_q;
               dx_d     = sh_dx_q;
               dy_d     = sh_dy_q;
               x0_d     = sh_x0_q;
               y0_d     = sh_y0_q;
               if (size_chg) begin
                  state_d      = ST_RESET_GEN;
                  gen_resetn_d = 1'b0;
                  rst_cnt_d    = '0;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end

         default: begin
            state_d      = ST_RESET_GEN;
            gen_resetn_d = 1'b0;
            rst_cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_RESET_GEN;
         rst_cnt_q     <= '0;
         gen_resetn_q  <= 1'b0;
         anim_en_q     <= 1'b0;
         frame_count_q <= '0;
         width_q       <= DEF_W;
         height_q      <= DEF_H;
         cr_q          <= '0;
         ci_q          <= '0;
         dx_q          <= '0;
         dy_q          <= '0;
         x0_q          <= '0;
         y0_q          <= '0;
         sh_width_q    <= DEF_W;
         sh_height_q   <= DEF_H;
         sh_cr_q       <= '0;
         sh_ci_q       <= '0;
         sh_dx_q       <= '0;
         sh_dy_q       <= '0;
         sh_x0_q       <= '0;
         sh_y0_q       <= '0;
         dcr_q         <= '0;
         dci_q         <= '0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         gen_resetn_q  <= gen_resetn_d;
         anim_en_q     <= anim_en_d;
         frame_count_q <= frame_count_d;
         width_q       <= width_d;
         height_q      <= height_d;
         cr_q          <= cr_d;
         ci_q          <= ci_d;
         dx_q          <= dx_d;
         dy_q          <= dy_d;
         x0_q          <= x0_d;
         y0_q          <= y0_d;
         sh_width_q    <= sh_width_d;
         sh_height_q   <= sh_height_d;
         sh_cr_q       <= sh_cr_d;
         sh_ci_q       <= sh_ci_d;
         sh_dx_q       <= sh_dx_d;
         sh_dy_q       <= sh_dy_d;
         sh_x0_q       <= sh_x0_d;
         sh_y0_q       <= sh_y0_d;
         dcr_q         <= dcr_d;
         dci_q         <= dci_d;
      end
   end

endmodule

// File: tb/tb_fractal_param_sequencer.sv
// Bench for fractal_param_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a register-map level model of shadow/active/commit behaviour.
module tb_fractal_param_sequencer;

   localparam int RST = 8;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        gen_frame_start;
   logic        gen_data_enable;
   logic        gen_resetn;
   logic [15:0] width, height;
   logic [31:0] cr, ci, dx, dy, x0, y0;
   logic        pending;
   logic [31:0] frame_count;

   int n_cmp = 0;
   int n_err = 0;

   fractal_param_sequencer #(
      .DEF_WIDTH(1920), .DEF_HEIGHT(1080), .RST_CYCLES(RST)
   ) dut (
      .clk(clk), .resetn(resetn),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .gen_frame_start(gen_frame_start), .gen_data_enable(gen_data_enable),
      .gen_resetn(gen_resetn), .width(width), .height(height),
      .cr(cr), .ci(ci), .dx(dx), .dy(dy), .x0(x0), .y0(y0),
      .pending(pending), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // Model: index 0..5 = cr,ci,dx,dy,x0,y0; sizes kept separately.
   logic [31:0] m_act [0:5];
   logic [31:0] m_sh  [0:5];
   logic [15:0] m_w, m_h, m_sw, m_shh;
   logic [31:0] m_dcr, m_dci, m_fc;
   logic        m_anim, m_pend;
   int          m_rst_left;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         m_act[i] = '0;
         m_sh[i]  = '0;
      end
      m_w = 16'd1920; m_h = 16'd1080; m_sw = 16'd1920; m_shh = 16'd1080;
      m_dcr = '0; m_dci = '0; m_fc = '0; m_anim = 1'b0; m_pend = 1'b0;
      m_rst_left = RST;
   endtask

   task automatic model_step();
      logic fb, hs, restart;
      fb = gen_frame_start && gen_data_enable && (m_rst_left == 0);
      hs = cfg_valid && (m_rst_left == 0) && !m_pend;
      restart = 1'b0;
      if (fb) begin
         m_fc = m_fc + 32'd1;
         if (m_pend) begin
            restart = (m_sw != m_w) || (m_shh != m_h);
            for (int i = 0; i < 6; i++) m_act[i] = m_sh[i];
            m_w = m_sw; m_h = m_shh;
            m_pend = 1'b0;
         end else if (m_anim) begin
            m_act[0] = m_act[0] + m_dcr;
            m_act[1] = m_act[1] + m_dci;
         end
      end
      if (hs) begin
         if (cfg_addr <= 4'd5) m_sh[cfg_addr] = cfg_data;
         else if (cfg_addr == 4'd6) begin m_sw = cfg_data[15:0]; m_shh = cfg_data[31:16]; end
         else if (cfg_addr == 4'd7) m_dcr = cfg_data;
         else if (cfg_addr == 4'd8) m_dci = cfg_data;
         else if (cfg_addr == 4'd9) begin
            m_anim = cfg_data[0];
            if (cfg_data[1]) m_pend = 1'b1;
         end
      end
      if (restart) m_rst_left = RST;
      else if (m_rst_left > 0) m_rst_left--;
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      cmp("gen_resetn",  {31'd0, gen_resetn}, {31'd0, m_rst_left == 0});
      cmp("cfg_ready",   {31'd0, cfg_ready},  {31'd0, (m_rst_left == 0) && !m_pend});
      cmp("pending",     {31'd0, pending},    {31'd0, m_pend});
      cmp("width",       {16'd0, width},      {16'd0, m_w});
      cmp("height",      {16'd0, height},     {16'd0, m_h});
      cmp("cr",          cr, m_act[0]);
      cmp("ci",          ci, m_act[1]);
      cmp("dx",          dx, m_act[2]);
      cmp("dy",          dy, m_act[3]);
      cmp("x0",          x0, m_act[4]);
      cmp("y0",          y0, m_act[5]);
      cmp("frame_count", frame_count, m_fc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic ok;
      ok = 1'b0;
      cfg_addr = a; cfg_data = d; cfg_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (cfg_ready) begin
            ok = 1'b1;
            tick();
            break;
         end
         tick();
      end
      cfg_valid = 1'b0;
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL wr_timeout addr %0d: got no cfg_ready in 200 cycles, expected acceptance", a);
      end
   endtask

   task automatic fb_pulse();
      gen_frame_start = 1'b1; gen_data_enable = 1'b1;
      tick();
      gen_frame_start = 1'b0; gen_data_enable = 1'b0;
   endtask

   initial begin
      int lows;
      cfg_valid = 0; cfg_addr = 0; cfg_data = 0;
      gen_frame_start = 0; gen_data_enable = 0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      // gen_resetn low for exactly RST cycles after release
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gen_resetn) break;
         lows++;
      end
      cmp("lit_rst_low_cycles", lows, 32'd8);
      @(posedge clk); #1;
      cmp("lit_width_def", {16'd0, width}, 32'd1920);
      cmp("lit_height_def", {16'd0, height}, 32'd1080);
      cmp("lit_cr_def", cr, 32'd0);
      cmp("lit_cfg_ready_run", {31'd0, cfg_ready}, 32'd1);

      // commit held off until a frame boundary
      wr(4'd0, 32'hF000_0000);
      wr(4'd1, 32'h0100_0000);
      wr(4'd9, 32'h2);
      repeat (100) tick();
      cmp("lit_cr_locked", cr, 32'd0);
      cmp("lit_pending_set", {31'd0, pending}, 32'd1);
      cmp("lit_cfg_ready_locked", {31'd0, cfg_ready}, 32'd0);
      fb_pulse();
      cmp("lit_cr_commit", cr, 32'hF000_0000);
      cmp("lit_ci_commit", ci, 32'h0100_0000);
      cmp("lit_pending_clr", {31'd0, pending}, 32'd0);
      cmp("lit_no_gen_reset", {31'd0, gen_resetn}, 32'd1);

      // size change -> generator reset window, FBs inside it ignored
      wr(4'd6, 32'h01E0_0280);
      wr(4'd9, 32'h2);
      fb_pulse();
      cmp("lit_width_640", {16'd0, width}, 32'd640);
      cmp("lit_height_480", {16'd0, height}, 32'd480);
      cmp("lit_gen_rst_first", {31'd0, gen_resetn}, 32'd0);
      gen_frame_start = 1'b1; gen_data_enable = 1'b1;
      repeat (7) tick();
      cmp("lit_gen_rst_last", {31'd0, gen_resetn}, 32'd0);
      tick();
      gen_frame_start = 1'b0; gen_data_enable = 1'b0;
      cmp("lit_gen_rst_done", {31'd0, gen_resetn}, 32'd1);
      cmp("lit_fc_no_bump", frame_count, 32'd2);

      // animation with signed wrap
      wr(4'd7, 32'h0010_0000);
      wr(4'd0, 32'h7FF0_0000);
      wr(4'd9, 32'h3);
      fb_pulse();
      cmp("lit_anim_base", cr, 32'h7FF0_0000);
      fb_pulse();
      cmp("lit_anim_step1", cr, 32'h8000_0000);
      fb_pulse();
      cmp("lit_anim_step2", cr, 32'h8010_0000);

      // commit beats animation on the same frame
      wr(4'd0, 32'h1234_5678);
      wr(4'd9, 32'h3);
      fb_pulse();
      cmp("lit_commit_no_step", cr, 32'h1234_5678);
      fb_pulse();
      cmp("lit_step_after_commit", cr, 32'h1244_5678);
      cmp("lit_ci_unanimated", ci, 32'h0100_0000);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_addr  = 4'($urandom_range(0, 15));
         cfg_data  = $urandom;
         if (cfg_addr == 4'd6 && $urandom_range(0, 1) == 0) cfg_data = 32'h01E0_0280;
         gen_frame_start = ($urandom_range(0, 5) == 0);
         gen_data_enable = ($urandom_range(0, 3) != 0);
         tick();
      end
      cfg_valid = 0; gen_frame_start = 0; gen_data_enable = 0;
      tick();

      // asynchronous reset while a commit is pending
      wr(4'd0, 32'hDEAD_BEEF);
      wr(4'd9, 32'h2);
      cmp("lit_pending_before_rst", {31'd0, pending}, 32'd1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      cmp("lit_async_pending", {31'd0, pending}, 32'd0);
      cmp("lit_async_width", {16'd0, width}, 32'd1920);
      cmp("lit_async_height", {16'd0, height}, 32'd1080);
      cmp("lit_async_fc", frame_count, 32'd0);
      cmp("lit_async_genrst", {31'd0, gen_resetn}, 32'd0);
      tick();
      resetn = 1'b1;
      repeat (RST + 1) tick();
      cmp("lit_ready_after_rst", {31'd0, cfg_ready}, 32'd1);
      wr(4'd9, 32'h2);
      fb_pulse();
      cmp("lit_shadow_discarded", cr, 32'd0);
      cmp("lit_fc_after_rst", frame_count, 32'd1);
      cmp("lit_no_reset_same_size", {31'd0, gen_resetn}, 32'd1);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
